// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the two-master picorv32 native-bus arbiter:
//   - FSM state encoding
//   - bus field widths
//   - default read data returned on a watchdog-terminated transaction
//   - helper to size the watchdog counter
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [DATA_W-1:0] TIMEOUT_RDATA_DEF = 32'hDEAD_BEEF;

  // Width of a counter that must reach TIMEOUT_CYCLES; never narrower than
  // one bit so the register still exists when the watchdog is disabled.
  function automatic int tcnt_width(input int cycles);
    if (cycles < 1) begin
      return 1;
    end else begin
      return $clog2(cycles + 1);
    end
  endfunction

endpackage : mem_bus_arbiter_pkg

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick.
// Ports:
//   req     [1:0] request vector, bit i = master i valid
//   last          index of the master granted most recently
//   gnt_idx       index of the master to grant (0 when no request)
//   any           at least one request is present
// A lone requester always wins; on contention the master that was not
// granted last time wins, which gives strict alternation under load.
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx,
  output logic       any
);

  // Pick the winner from the request pattern and the previous grant.
  always_comb begin
    gnt_idx = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
  end

  assign any = |req;

endmodule : rr_arb2

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Two-master, one-slave arbiter for the picorv32 native memory bus.
// Parameters:
//   TIMEOUT_CYCLES  BUSY cycles without s_ready before forced completion
//                   (0 disables the watchdog)
//   TIMEOUT_RDATA   read data returned on a timed-out transaction
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m0_* / m1_*              master request side (valid/instr/addr/wdata/wstrb
//                            in, ready/rdata out); m0 is the CPU
//   s_*                      slave request side (valid/instr/addr/wdata/wstrb
//                            out, ready/rdata in)
//   timeout_err              one-cycle pulse when the watchdog completes a
//                            transaction
//   err_master               index of the master that last timed out (sticky)
// Operation: IDLE samples the requests and registers a grant; BUSY drives the
// granted master onto the slave until s_ready or the watchdog completes it.
// IDLE never looks at s_ready, which swallows the trailing ready of slaves
// that register their handshake.
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int                 TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]  TIMEOUT_RDATA  = TIMEOUT_RDATA_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_valid,
  input  logic              m0_instr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_valid,
  input  logic              m1_instr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              s_valid,
  output logic              s_instr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,

  output logic              timeout_err,
  output logic              err_master
);

  localparam int                TCNT_W    = tcnt_width(TIMEOUT_CYCLES);
  localparam logic              WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TCNT_W-1:0] TCNT_LAST =
    TCNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = '1;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                err_master_q, err_master_d;

  logic                arb_idx_s;
  logic                arb_any_s;
  logic                busy_s;
  logic                slave_done_s;
  logic                wdog_fire_s;
  logic                cpl_s;
  logic [DATA_W-1:0]   cpl_rdata_s;

  rr_arb2 u_rr_arb2 (
    .req     ({m1_valid, m0_valid}),
    .last    (last_grant_q),
    .gnt_idx (arb_idx_s),
    .any     (arb_any_s)
  );

  assign busy_s       = (state_q == ST_BUSY);
  assign slave_done_s = busy_s & s_ready;
  // The slave handshake takes precedence over a watchdog expiring in the
  // same cycle, so real data is never replaced by the error pattern.
  assign wdog_fire_s  = busy_s & ~s_ready & WDOG_EN & (tcnt_q == TCNT_LAST);
  assign cpl_s        = slave_done_s | wdog_fire_s;
  assign cpl_rdata_s  = slave_done_s ? s_rdata : TIMEOUT_RDATA;

  // Next-state logic for the IDLE/BUSY controller, grant and watchdog.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tcnt_d       = tcnt_q;
    err_master_d = err_master_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any_s) begin
          state_d = ST_BUSY;
          grant_d = arb_idx_s;
          tcnt_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Saturate so a disabled watchdog cannot wrap into a false match.
        if (tcnt_q != TCNT_MAX) begin
          tcnt_d = tcnt_q + 1'b1;
        end else begin
          tcnt_d = tcnt_q;
        end
        if (cpl_s) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
          if (wdog_fire_s) begin
            err_master_d = grant_q;
          end else begin
            err_master_d = err_master_q;
          end
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state registers; last_grant resets to 1 so m0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      tcnt_q       <= '0;
      err_master_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tcnt_q       <= tcnt_d;
      err_master_q <= err_master_d;
    end
  end

  // Slave request mux: driven only in BUSY, zero otherwise.
  always_comb begin
    s_valid = busy_s;
    s_instr = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    if (busy_s) begin
      if (grant_q) begin
        s_instr = m1_instr;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wstrb = m1_wstrb;
      end else begin
        s_instr = m0_instr;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wstrb = m0_wstrb;
      end
    end else begin
      s_instr = 1'b0;
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
    end
  end

  // Completion return: only the granted master sees ready/rdata, and only in
  // the completion cycle.
  always_comb begin
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (cpl_s) begin
      if (grant_q) begin
        m1_ready = 1'b1;
        m1_rdata = cpl_rdata_s;
      end else begin
        m0_ready = 1'b1;
        m0_rdata = cpl_rdata_s;
      end
    end else begin
      m0_ready = 1'b0;
      m1_ready = 1'b0;
    end
  end

  assign timeout_err = wdog_fire_s;
  assign err_master  = err_master_q;

endmodule : mem_bus_arbiter
